// File: rtl/life_pkg.sv
// Shared lives-state types and the default lives constants also used by the HUD lives compositor.
// Pure declarations: no latency and no flow control.
package life_pkg;

    typedef enum logic [1:0] {
        LS_PLAY  = 2'd0,
        LS_GRACE = 2'd1,
        LS_OVER  = 2'd2
    } life_state_t;

    localparam int DEFAULT_MAX_LIVES   = 3;
    localparam int DEFAULT_START_LIVES = 3;
    localparam int DEFAULT_LIVES_W     = $clog2(DEFAULT_MAX_LIVES + 1);

    // Sprite is visible during the even half-phases of the grace window.
    function automatic logic blink_visible(input int frame_cnt, input int period);
        return ((frame_cnt / period) % 2) == 0;
    endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector: registers the previous sample and flags in & ~in_q.
// The rise output is combinational from i_d (same cycle as the new level); no backpressure.
module rise_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise
);

    logic r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/life_manager.sv
// Player lives FSM: hit decrement, frame-counted grace blink, bonus lives, game-over hold and restart.
// All outputs registered, 1-cycle response to the sampled input edge; no backpressure, inputs never stalled.
module life_manager
    import life_pkg::*;
#(
    parameter int MAX_LIVES        = DEFAULT_MAX_LIVES,
    parameter int START_LIVES      = DEFAULT_START_LIVES,
    parameter int GRACE_FRAMES     = 60,
    parameter int BLINK_PERIOD     = 8,
    parameter int OVER_HOLD_FRAMES = 120,
    parameter int LIVES_W          = $clog2(MAX_LIVES + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_v_sync,
    input  logic               i_barrier_hit,
    input  logic               i_bonus,
    input  logic               i_restart,
    output logic [LIVES_W-1:0] o_lives,
    output logic               o_blink_on,
    output logic               o_invulnerable,
    output logic               o_life_lost,
    output logic               o_out_of_lives,
    output logic               o_game_active
);

    localparam int FRAME_W = $clog2(GRACE_FRAMES + 1);
    localparam int HOLD_W  = $clog2(OVER_HOLD_FRAMES + 1);

    localparam logic [LIVES_W-1:0] L_MAX   = LIVES_W'(MAX_LIVES);
    localparam logic [LIVES_W-1:0] L_START = LIVES_W'(START_LIVES);
    localparam logic [LIVES_W-1:0] L_ONE   = LIVES_W'(1);
    localparam logic [FRAME_W-1:0] F_LAST  = FRAME_W'(GRACE_FRAMES - 1);
    localparam logic [HOLD_W-1:0]  H_FULL  = HOLD_W'(OVER_HOLD_FRAMES);

    logic w_tick;
    logic w_hit;
    logic w_restart;

    rise_edge_det u_vsync_det (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_v_sync),
        .o_rise (w_tick)
    );

    rise_edge_det u_hit_det (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_barrier_hit),
        .o_rise (w_hit)
    );

    rise_edge_det u_restart_det (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_restart),
        .o_rise (w_restart)
    );

    life_state_t        r_state;
    logic [LIVES_W-1:0] r_lives;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               r_blink_on;
    logic               r_life_lost;

    life_state_t        w_state_nxt;
    logic [LIVES_W-1:0] w_lives_nxt;
    logic [FRAME_W-1:0] w_frame_nxt;
    logic [HOLD_W-1:0]  w_hold_nxt;
    logic               w_blink_nxt;
    logic               w_lost_nxt;
    logic [FRAME_W-1:0] w_frame_inc;

    assign w_frame_inc = r_frame_cnt + FRAME_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_lives_nxt = r_lives;
        w_frame_nxt = r_frame_cnt;
        w_hold_nxt  = r_hold_cnt;
        w_blink_nxt = r_blink_on;
        w_lost_nxt  = 1'b0;

        case (r_state)
            LS_PLAY: begin
                // A hit takes priority over a same-cycle bonus; a same-cycle tick is absorbed.
                if (w_hit) begin
                    w_lost_nxt = 1'b1;
                    if (r_lives > L_ONE) begin
                        w_lives_nxt = r_lives - L_ONE;
                        w_frame_nxt = '0;
                        w_blink_nxt = 1'b1;
                        w_state_nxt = LS_GRACE;
                    end else begin
                        w_lives_nxt = '0;
                        w_hold_nxt  = '0;
                        w_state_nxt = LS_OVER;
                    end
                end else if (i_bonus && (r_lives < L_MAX)) begin
                    w_lives_nxt = r_lives + L_ONE;
                end
            end

            LS_GRACE: begin
                if (i_bonus && (r_lives < L_MAX)) begin
                    w_lives_nxt = r_lives + L_ONE;
                end
                if (w_tick) begin
                    if (r_frame_cnt == F_LAST) begin
                        w_frame_nxt = '0;
                        w_blink_nxt = 1'b1;
                        w_state_nxt = LS_PLAY;
                    end else begin
                        w_frame_nxt = w_frame_inc;
                        w_blink_nxt = blink_visible(int'(w_frame_inc), BLINK_PERIOD);
                    end
                end
            end

            LS_OVER: begin
                if (w_tick && (r_hold_cnt < H_FULL)) begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
                // Restart only counts once the hold has fully elapsed; early requests are dropped.
                if (w_restart && (r_hold_cnt == H_FULL)) begin
                    w_lives_nxt = L_START;
                    w_hold_nxt  = '0;
                    w_frame_nxt = '0;
                    w_blink_nxt = 1'b1;
                    w_state_nxt = LS_PLAY;
                end
            end

            default: begin
                w_state_nxt = LS_PLAY;
                w_lives_nxt = L_START;
                w_frame_nxt = '0;
                w_hold_nxt  = '0;
                w_blink_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= LS_PLAY;
            r_lives     <= L_START;
            r_frame_cnt <= '0;
            r_hold_cnt  <= '0;
            r_blink_on  <= 1'b1;
            r_life_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lives     <= w_lives_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_blink_on  <= w_blink_nxt;
            r_life_lost <= w_lost_nxt;
        end
    end

    assign o_lives        = r_lives;
    assign o_blink_on     = r_blink_on;
    assign o_life_lost    = r_life_lost;
    assign o_invulnerable = (r_state == LS_GRACE);
    assign o_out_of_lives = (r_state == LS_OVER);
    assign o_game_active  = (r_state != LS_OVER);

endmodule
